// File: rtl/ldtu_dec_pkg.sv
// Shared definitions for the LiTe-DTU stream decoder: header codes, field
// widths, word-kind and FSM state encodings.
package ldtu_dec_pkg;

  localparam int BAS_W     = 6;
  localparam int SIG_W     = 13;
  localparam int BAS_FULL_N = 5;

  localparam logic [1:0] HDR_BASE_FULL = 2'b01;
  localparam logic [3:0] HDR_BASE_PART = 4'b1100;
  localparam logic [5:0] HDR_SIGN_2    = 6'b001010;
  localparam logic [5:0] HDR_SIGN_1    = 6'b001011;
  localparam logic [3:0] HDR_HEADER    = 4'b1101;
  localparam logic [3:0] HDR_IDLE      = 4'b1110;

  typedef enum logic [2:0] {
    K_BASE_FULL = 3'd0,
    K_BASE_PART = 3'd1,
    K_SIGN_2    = 3'd2,
    K_SIGN_1    = 3'd3,
    K_HEADER    = 3'd4,
    K_IDLE      = 3'd5,
    K_BAD       = 3'd6
  } word_kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BAS  = 2'd1,
    S_SIG  = 2'd2
  } state_e;

endpackage

// File: rtl/ldtu_word_classify.sv
// Combinational classifier: looks at the top byte of a compressed word and
// reports its kind, how many samples it carries and whether it is malformed.
module ldtu_word_classify
  import ldtu_dec_pkg::*;
(
  input  logic [7:0] i_hdr,
  output logic [2:0] o_kind,
  output logic [2:0] o_nsamples,
  output logic       o_malformed
);

  word_kind_e w_kind;
  logic [2:0] w_n;

  // Decode header bits; a partial-baseline count outside 1..4 is malformed
  always_comb begin
    w_kind = K_BAD;
    w_n    = 3'd0;
    if (i_hdr[7:6] == HDR_BASE_FULL) begin
      w_kind = K_BASE_FULL;
      w_n    = 3'(BAS_FULL_N);
    end else if (i_hdr[7:4] == HDR_BASE_PART) begin
      if ((i_hdr[3:0] != 4'd0) && (i_hdr[3:0] <= 4'd4)) begin
        w_kind = K_BASE_PART;
        w_n    = i_hdr[2:0];
      end
    end else if (i_hdr[7:2] == HDR_SIGN_2) begin
      w_kind = K_SIGN_2;
      w_n    = 3'd2;
    end else if (i_hdr[7:2] == HDR_SIGN_1) begin
      w_kind = K_SIGN_1;
      w_n    = 3'd1;
    end else if (i_hdr[7:4] == HDR_HEADER) begin
      w_kind = K_HEADER;
    end else if (i_hdr[7:4] == HDR_IDLE) begin
      w_kind = K_IDLE;
    end
  end

  assign o_kind      = w_kind;
  assign o_nsamples  = w_n;
  assign o_malformed = (w_kind == K_BAD);

endmodule

// File: rtl/ldtu_stream_decoder.sv
// LiTe-DTU receive-side stream decoder: unpacks baseline/signal words into one
// sample per clock, pulses orbit_o on HEADER words and err_o on malformed words.
// Optional feature: define LDTU_DEC_ERRCNT_EN to add the saturating err_cnt_o.
module ldtu_stream_decoder
  import ldtu_dec_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SMP_W  = 13
`ifdef LDTU_DEC_ERRCNT_EN
  , parameter int ERRCNT_W = 16
`endif
)
(
  input  logic              CLK,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic [SMP_W-1:0]  sample_o,
  output logic              sample_val_o,
  output logic              baseline_o,
  output logic              orbit_o,
  output logic              err_o
`ifdef LDTU_DEC_ERRCNT_EN
  , output logic [ERRCNT_W-1:0] err_cnt_o
`endif
);

  state_e            r_state, w_nxt_state;
  logic [WORD_W-1:0] r_buf, w_nxt_buf;
  logic [2:0]        r_rem, w_nxt_rem;
  logic              r_orb_pend, w_nxt_orb;
  logic              r_err_pend, w_nxt_err;

  logic [SMP_W-1:0]  r_sample;
  logic              r_sample_val;
  logic              r_baseline;
  logic              r_orbit;
  logic              r_err;

  logic [2:0]        w_kind_raw;
  word_kind_e        w_kind;
  logic [2:0]        w_nsamp;
  logic              w_malformed;
  logic              w_accept;

  ldtu_word_classify u_classify (
    .i_hdr       (word_i[WORD_W-1:WORD_W-8]),
    .o_kind      (w_kind_raw),
    .o_nsamples  (w_nsamp),
    .o_malformed (w_malformed)
  );

  assign w_kind       = word_kind_e'(w_kind_raw);
  // A new word can be taken while idle or on the cycle the last sample leaves,
  // which is what keeps back-to-back words free of bubbles.
  assign word_ready_o = (r_state == S_IDLE) | (r_rem == 3'd1);
  assign w_accept     = word_valid_i & word_ready_o;

  // Next-state: drain the buffer one field per cycle, then load on accept
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_buf   = r_buf;
    w_nxt_rem   = r_rem;
    w_nxt_orb   = 1'b0;
    w_nxt_err   = 1'b0;
    case (r_state)
      S_BAS: begin
        w_nxt_buf = r_buf >> BAS_W;
        w_nxt_rem = r_rem - 3'd1;
        if (r_rem == 3'd1) w_nxt_state = S_IDLE;
      end
      S_SIG: begin
        w_nxt_buf = r_buf >> SIG_W;
        w_nxt_rem = r_rem - 3'd1;
        if (r_rem == 3'd1) w_nxt_state = S_IDLE;
      end
      default: ;
    endcase
    if (w_accept) begin
      if (w_malformed) begin
        w_nxt_err   = 1'b1;
        w_nxt_state = S_IDLE;
        w_nxt_rem   = 3'd0;
      end else begin
        case (w_kind)
          K_BASE_FULL, K_BASE_PART: begin
            w_nxt_state = S_BAS;
            w_nxt_buf   = word_i;
            w_nxt_rem   = w_nsamp;
          end
          K_SIGN_2, K_SIGN_1: begin
            w_nxt_state = S_SIG;
            w_nxt_buf   = word_i;
            w_nxt_rem   = w_nsamp;
          end
          K_HEADER: begin
            w_nxt_orb   = 1'b1;
            w_nxt_state = S_IDLE;
            w_nxt_rem   = 3'd0;
          end
          default: begin
            w_nxt_state = S_IDLE;
            w_nxt_rem   = 3'd0;
          end
        endcase
      end
    end
  end

  // State, shift buffer, remaining count and one-cycle event pending flags
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      r_rem      <= 3'd0;
      r_orb_pend <= 1'b0;
      r_err_pend <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_buf      <= w_nxt_buf;
      r_rem      <= w_nxt_rem;
      r_orb_pend <= w_nxt_orb;
      r_err_pend <= w_nxt_err;
    end
  end

  // Output registers: emit the low field while busy, hold sample otherwise.
  // Orbit/error pulses are delayed one cycle so they line up with sample timing.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_sample     <= '0;
      r_sample_val <= 1'b0;
      r_baseline   <= 1'b0;
      r_orbit      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_sample_val <= (r_state != S_IDLE);
      r_orbit      <= r_orb_pend;
      r_err        <= r_err_pend;
      if (r_state == S_BAS) begin
        r_sample   <= SMP_W'(r_buf[BAS_W-1:0]);
        r_baseline <= 1'b1;
      end else if (r_state == S_SIG) begin
        r_sample   <= SMP_W'(r_buf[SIG_W-1:0]);
        r_baseline <= 1'b0;
      end
    end
  end

  assign sample_o     = r_sample;
  assign sample_val_o = r_sample_val;
  assign baseline_o   = r_baseline;
  assign orbit_o      = r_orbit;
  assign err_o        = r_err;

`ifdef LDTU_DEC_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  // Saturating count of error pulses, cleared only by reset
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= '0;
    end else if (r_err_pend && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_ldtu_stream_decoder.sv
// Self-checking bench for ldtu_stream_decoder: a word-level model predicts the
// ordered event stream, a per-cycle compare process checks it, and directed
// tests pin timing and values with hand-computed literals.
module tb_ldtu_stream_decoder;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] word_i = 32'h0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o;
  logic [12:0] sample_o;
  logic        sample_val_o;
  logic        baseline_o;
  logic        orbit_o;
  logic        err_o;
`ifdef LDTU_DEC_ERRCNT_EN
  logic [15:0] err_cnt_o;
`endif

  ldtu_stream_decoder dut (
    .CLK          (CLK),
    .reset        (reset),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .sample_o     (sample_o),
    .sample_val_o (sample_val_o),
    .baseline_o   (baseline_o),
    .orbit_o      (orbit_o),
    .err_o        (err_o)
`ifdef LDTU_DEC_ERRCNT_EN
    , .err_cnt_o  (err_cnt_o)
`endif
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // kind: 0 sample, 1 orbit, 2 error
  typedef struct {
    int kind;
    int val;
    bit base;
  } ev_t;

  ev_t exp_q[$];
  int  lg_cyc[$];
  int  lg_kind[$];
  int  lg_val[$];
  int  last_smp  = 0;
  int  last_base = 0;

  int rdy_exp[6] = '{0, 0, 0, 0, 1, 1};

  localparam logic [31:0] W_BFULL = 32'h4510_3081; // samples 1,2,3,4,5

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Word-level model: turn one accepted word into its ordered output events
  function automatic void model_word(input logic [31:0] w);
    ev_t e;
    int  n;
    e.kind = 0; e.val = 0; e.base = 1'b0;
    if (w[31:30] == 2'b01) begin
      for (int i = 0; i < 5; i++) begin
        e.kind = 0; e.val = int'((w >> (6 * i)) & 32'h3F); e.base = 1'b1;
        exp_q.push_back(e);
      end
    end else if (w[31:28] == 4'hC) begin
      n = int'(w[27:24]);
      if (n >= 1 && n <= 4) begin
        for (int i = 0; i < n; i++) begin
          e.kind = 0; e.val = int'((w >> (6 * i)) & 32'h3F); e.base = 1'b1;
          exp_q.push_back(e);
        end
      end else begin
        e.kind = 2; exp_q.push_back(e);
      end
    end else if (w[31:26] == 6'b001010) begin
      e.kind = 0; e.base = 1'b0;
      e.val = int'(w & 32'h1FFF);         exp_q.push_back(e);
      e.val = int'((w >> 13) & 32'h1FFF); exp_q.push_back(e);
    end else if (w[31:26] == 6'b001011) begin
      e.kind = 0; e.base = 1'b0; e.val = int'(w & 32'h1FFF);
      exp_q.push_back(e);
    end else if (w[31:28] == 4'hD) begin
      e.kind = 1; exp_q.push_back(e);
    end else if (w[31:28] != 4'hE) begin
      e.kind = 2; exp_q.push_back(e);
    end
  endfunction

  // Per-cycle compare against the model, plus exclusivity and hold checks
  always @(negedge CLK) begin : cmp
    int  nev;
    int  kind;
    ev_t e;
    if (reset) begin
      nev = int'(sample_val_o) + int'(orbit_o) + int'(err_o);
      chk("exclusive", int'(nev <= 1), 1);
      if (nev != 0) begin
        kind = sample_val_o ? 0 : (orbit_o ? 1 : 2);
        lg_cyc.push_back(cyc);
        lg_kind.push_back(kind);
        lg_val.push_back(int'(sample_o));
        if (exp_q.size() == 0) begin
          chk("unexpected_event", kind, -1);
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind", kind, e.kind);
          if (kind == 0) begin
            chk("ev_sample", int'(sample_o), e.val);
            chk("ev_baseline", int'(baseline_o), int'(e.base));
          end
        end
      end
      if (sample_val_o) begin
        last_smp  = int'(sample_o);
        last_base = int'(baseline_o);
      end else begin
        chk("hold_sample", int'(sample_o), last_smp);
        chk("hold_baseline", int'(baseline_o), last_base);
      end
    end else begin
      last_smp  = 0;
      last_base = 0;
    end
  end

  task automatic lg_clear();
    lg_cyc.delete();
    lg_kind.delete();
    lg_val.delete();
  endtask

  // Present a word and hold it until accepted; valid is left high on return
  task automatic send(input logic [31:0] w);
    bit rdy;
    int n;
    word_i = w;
    word_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      rdy = word_ready_o;
      @(posedge CLK);
      n++;
    end while (!rdy && n < 60);
    #1;
    if (!rdy) begin
      chk("accept_timeout", 0, 1);
      word_valid_i = 1'b0;
    end else begin
      model_word(w);
      acc_cyc = cyc;
    end
  endtask

  task automatic gap(input int n);
    word_valid_i = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int t;
    int n;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", int'(word_ready_o), 1);
    chk("rst_sample_val", int'(sample_val_o), 0);
    chk("rst_sample", int'(sample_o), 0);
    chk("rst_orbit", int'(orbit_o), 0);
    chk("rst_err", int'(err_o), 0);
    reset = 1'b1;
    @(posedge CLK); #1;

    // 1: BASE_FULL, samples 1..5, ready only in the last emit cycle
    lg_clear();
    send(W_BFULL);
    word_valid_i = 1'b0;
    t = acc_cyc;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("t1_ready", int'(word_ready_o), rdy_exp[k]);
    end
    gap(3);
    chk("t1_count", lg_val.size(), 5);
    if (lg_val.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t1_value", lg_val[k], k + 1);
        chk("t1_cycle", lg_cyc[k], t + 1 + k);
      end
    end

    // 2: SIGN_2 then SIGN_1 back-to-back
    lg_clear();
    send({6'b001010, 13'h0ABC, 13'h1234});
    t = acc_cyc;
    send({6'b001011, 13'h0000, 13'h0FFF});
    chk("t2_second_accept", acc_cyc, t + 2);
    gap(5);
    chk("t2_count", lg_val.size(), 3);
    if (lg_val.size() == 3) begin
      chk("t2_v0", lg_val[0], 'h1234);
      chk("t2_v1", lg_val[1], 'h0ABC);
      chk("t2_v2", lg_val[2], 'h0FFF);
      chk("t2_c0", lg_cyc[0], t + 1);
      chk("t2_c2", lg_cyc[2], t + 3);
    end

    // 3: BASE_PART N=3 (3F,00,15) then HEADER
    lg_clear();
    send(32'hC301_503F);
    t = acc_cyc;
    send(32'hD000_0000);
    gap(5);
    chk("t3_count", lg_val.size(), 4);
    if (lg_val.size() == 4) begin
      chk("t3_v0", lg_val[0], 'h3F);
      chk("t3_v1", lg_val[1], 'h00);
      chk("t3_v2", lg_val[2], 'h15);
      chk("t3_orbit_kind", lg_kind[3], 1);
      chk("t3_orbit_cycle", lg_cyc[3], t + 4);
    end

    // 4: malformed words
    lg_clear();
    send(32'hC000_0000);
    t = acc_cyc;
    send(32'hFFFF_FFFF);
    gap(4);
    chk("t4_count", lg_kind.size(), 2);
    if (lg_kind.size() == 2) begin
      chk("t4_k0", lg_kind[0], 2);
      chk("t4_k1", lg_kind[1], 2);
      chk("t4_c1", lg_cyc[1], t + 2);
    end
`ifdef LDTU_DEC_ERRCNT_EN
    chk("t4_errcnt", int'(err_cnt_o), 2);
    force dut.r_err_cnt = 16'hFFFF;
    @(posedge CLK); #1;
    release dut.r_err_cnt;
    send(32'hFFFF_FFFF);
    gap(3);
    chk("t4_errcnt_sat", int'(err_cnt_o), 'hFFFF);
`endif

    // 5: reset during the 3rd sample of BASE_FULL
    lg_clear();
    send(W_BFULL);
    word_valid_i = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(sample_val_o && sample_o == 13'd3) && n < 20);
    chk("t5_reached_third", int'(sample_o), 3);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_val_cleared", int'(sample_val_o), 0);
    chk("t5_sample_cleared", int'(sample_o), 0);
    chk("t5_base_cleared", int'(baseline_o), 0);
    exp_q.delete();
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("t5_ready_after", int'(word_ready_o), 1);
    repeat (4) @(posedge CLK);
    #1;
    chk("t5_no_more", lg_val.size(), 3);
    lg_clear();
    send({6'b001011, 13'h1555, 13'h0123});
    t = acc_cyc;
    gap(4);
    chk("t5_sign1_count", lg_val.size(), 1);
    if (lg_val.size() == 1) begin
      chk("t5_sign1_val", lg_val[0], 'h0123);
      chk("t5_sign1_cyc", lg_cyc[0], t + 1);
    end

    // 6: IDLE words with valid gaps
    lg_clear();
    for (int i = 0; i < 4; i++) begin
      send(32'hE000_0000 | (32'h0123_4567 * i));
      word_valid_i = 1'b0;
      @(negedge CLK);
      chk("t6_ready", int'(word_ready_o), 1);
      gap(i + 1);
    end
    chk("t6_no_output", lg_kind.size(), 0);

    gap(5);
    chk("model_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
